// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One transaction at a time: IDLE (grant) -> ISSUE (memory strobe) -> RESP (ack).
module dmem_arbiter #(
    parameter int unsigned ADDRSIZE = 5,
    parameter int unsigned WORDSIZE = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [ADDRSIZE-1:0] addr0,
    input  logic [ADDRSIZE-1:0] addr1,
    input  logic [WORDSIZE-1:0] wdata0,
    input  logic [WORDSIZE-1:0] wdata1,
    input  logic [WORDSIZE-1:0] mem_rdata,
    output logic                ack0,
    output logic                ack1,
    output logic [WORDSIZE-1:0] rdata,
    output logic                busy,
    output logic                mem_read,
    output logic                mem_write,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WORDSIZE-1:0] mem_wdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                owner_q, owner_d;
    logic                we_q, we_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                busy_q, busy_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [ADDRSIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORDSIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic [WORDSIZE-1:0] rdata_q, rdata_d;
    logic                grant1;
    logic                we_sel;

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Next-state and next-output logic; strobes and acks are computed one
    // state ahead so they appear registered in the state they belong to.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        we_d        = we_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        busy_d      = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        grant1      = 1'b0;
        we_sel      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Requester 1 wins when alone, or when contended and preferred.
                    grant1      = req1 && (!req0 || ptr_q);
                    we_sel      = grant1 ? we1 : we0;
                    owner_d     = grant1;
                    ptr_d       = !grant1;
                    we_d        = we_sel;
                    mem_addr_d  = grant1 ? addr1 : addr0;
                    mem_wdata_d = grant1 ? wdata1 : wdata0;
                    mem_read_d  = !we_sel;
                    mem_write_d = we_sel;
                    busy_d      = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                ack0_d  = !owner_q;
                ack1_d  = owner_q;
                busy_d  = 1'b1;
                state_d = RESP;
            end
            RESP: begin
                if (!we_q) begin
                    rdata_d = mem_rdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Memory data arrives during RESP, so a read result bypasses the holding register.
    assign rdata     = (state_q == RESP && !we_q) ? mem_rdata : rdata_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign busy      = busy_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    a_strobe_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(mem_read_q && mem_write_q));
    a_ack_excl: assert property (@(posedge clk) disable iff (!reset_n)
        !(ack0_q && ack1_q));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus corner-case sequences.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1, we0, we1;
    logic [4:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic [31:0] mem_rdata = 32'h0;
    logic        ack0, ack1, busy, mem_read, mem_write;
    logic [31:0] rdata, mem_wdata;
    logic [4:0]  mem_addr;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [32];
    logic        mem_ready = 1'b0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDRSIZE(5), .WORDSIZE(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .mem_rdata (mem_rdata),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .busy      (busy),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata)
    );

    // Synchronous data memory; word i powers up as 0xA0000000 + i.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            mem_ready <= 1'b1;
        end else begin
            if (mem_write) mem[mem_addr] <= mem_wdata;
            if (mem_read)  mem_rdata <= mem[mem_addr];
        end
    end

    // Exclusivity of acks and of memory strobes, every cycle out of reset.
    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if (ack0 && ack1) begin
                failures++;
                $display("FAIL ack_excl got ack0=%0d ack1=%0d exp not both", ack0, ack1);
            end
            checks++;
            if (mem_read && mem_write) begin
                failures++;
                $display("FAIL strobe_excl got rd=%0d wr=%0d exp not both", mem_read, mem_write);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst, r0, r1, w0, w1;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic        k0, k1, bz, mr, mw;
        logic [4:0]  ma;
        logic [31:0] md, rd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic r0, input logic r1,
                       input logic w0, input logic w1,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1,
                       input logic k0, input logic k1, input logic bz,
                       input logic mr, input logic mw,
                       input logic [4:0] ma, input logic [31:0] md,
                       input logic [31:0] rd);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.k0 = k0; v.k1 = k1; v.bz = bz; v.mr = mr; v.mw = mw;
        v.ma = ma; v.md = md; v.rd = rd;
        vq.push_back(v);
    endtask

    task automatic check(input string nm, input int row,
                         input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%h exp=%h", nm, row, got, exp);
        end
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 5'd0; addr1 = 5'd0; wdata0 = 32'h0; wdata1 = 32'h0;

        //  rst r0 r1 w0 w1  a0  a1  d0            d1        k0 k1 bz mr mw  ma  md            rd
        add(0, 0, 0, 0, 0,  0,  0, 32'h0,        32'h0,    0, 0, 0, 0, 0,  0, 32'h0,        32'h0);
        add(1, 0, 0, 0, 0,  0,  0, 32'h0,        32'h0,    0, 0, 0, 0, 0,  0, 32'h0,        32'h0);
        // single write, then read back through the memory
        add(1, 1, 0, 1, 0,  5,  0, 32'hDEADBEEF, 32'h0,    0, 0, 1, 0, 1,  5, 32'hDEADBEEF, 32'h0);
        add(1, 0, 0, 1, 0,  5,  0, 32'hDEADBEEF, 32'h0,    1, 0, 1, 0, 0,  5, 32'hDEADBEEF, 32'h0);
        add(1, 0, 0, 0, 0,  5,  0, 32'hDEADBEEF, 32'h0,    0, 0, 0, 0, 0,  5, 32'hDEADBEEF, 32'h0);
        add(1, 0, 1, 0, 0,  5,  5, 32'h0,        32'h0,    0, 0, 1, 1, 0,  5, 32'h0,        32'h0);
        add(1, 0, 0, 0, 0,  5,  5, 32'h0,        32'h0,    0, 1, 1, 0, 0,  5, 32'h0,        32'hDEADBEEF);
        add(1, 0, 0, 0, 0,  5,  5, 32'h0,        32'h0,    0, 0, 0, 0, 0,  5, 32'h0,        32'hDEADBEEF);
        // reset, then both requesters held: round-robin 0,1,0,1
        add(0, 0, 0, 0, 0,  0,  0, 32'h0,        32'h0,    0, 0, 0, 0, 0,  0, 32'h0,        32'h0);
        add(1, 1, 1, 1, 1,  1,  2, 32'h11,       32'h22,   0, 0, 1, 0, 1,  1, 32'h11,       32'h0);
        add(1, 1, 1, 1, 1,  1,  2, 32'h11,       32'h22,   1, 0, 1, 0, 0,  1, 32'h11,       32'h0);
        add(1, 1, 1, 1, 1,  1,  2, 32'h11,       32'h22,   0, 0, 0, 0, 0,  1, 32'h11,       32'h0);
        add(1, 1, 1, 1, 1,  1,  2, 32'h11,       32'h22,   0, 0, 1, 0, 1,  2, 32'h22,       32'h0);
        add(1, 1, 1, 1, 1,  1,  2, 32'h11,       32'h22,   0, 1, 1, 0, 0,  2, 32'h22,       32'h0);
        add(1, 1, 1, 1, 1,  1,  2, 32'h11,       32'h22,   0, 0, 0, 0, 0,  2, 32'h22,       32'h0);
        add(1, 1, 1, 1, 1,  1,  2, 32'h11,       32'h22,   0, 0, 1, 0, 1,  1, 32'h11,       32'h0);
        add(1, 1, 1, 1, 1,  1,  2, 32'h11,       32'h22,   1, 0, 1, 0, 0,  1, 32'h11,       32'h0);
        add(1, 1, 1, 1, 1,  1,  2, 32'h11,       32'h22,   0, 0, 0, 0, 0,  1, 32'h11,       32'h0);
        add(1, 1, 1, 1, 1,  1,  2, 32'h11,       32'h22,   0, 0, 1, 0, 1,  2, 32'h22,       32'h0);
        add(1, 1, 1, 1, 1,  1,  2, 32'h11,       32'h22,   0, 1, 1, 0, 0,  2, 32'h22,       32'h0);
        add(1, 0, 0, 1, 1,  1,  2, 32'h11,       32'h22,   0, 0, 0, 0, 0,  2, 32'h22,       32'h0);
        // addr1 changes 3 -> 7 during ISSUE; transaction keeps address 3
        add(1, 0, 1, 0, 0,  0,  3, 32'h0,        32'h0,    0, 0, 1, 1, 0,  3, 32'h0,        32'h0);
        add(1, 0, 0, 0, 0,  0,  7, 32'h0,        32'h0,    0, 1, 1, 0, 0,  3, 32'h0,        32'hA0000003);
        add(1, 0, 0, 0, 0,  0,  7, 32'h0,        32'h0,    0, 0, 0, 0, 0,  3, 32'h0,        32'hA0000003);
        // reset during the ISSUE of a write aborts it; requester 0 wins afterwards
        add(1, 1, 0, 1, 0,  9,  0, 32'h55,       32'h0,    0, 0, 1, 0, 1,  9, 32'h55,       32'hA0000003);
        add(0, 1, 1, 1, 0,  9,  0, 32'h55,       32'h0,    0, 0, 0, 0, 0,  0, 32'h0,        32'h0);
        add(1, 1, 1, 0, 0,  9,  2, 32'h0,        32'h0,    0, 0, 1, 1, 0,  9, 32'h0,        32'h0);
        add(1, 0, 1, 0, 0,  9,  2, 32'h0,        32'h0,    1, 0, 1, 0, 0,  9, 32'h0,        32'hA0000009);
        add(1, 0, 1, 0, 0,  9,  2, 32'h0,        32'h0,    0, 0, 0, 0, 0,  9, 32'h0,        32'hA0000009);
        add(1, 0, 1, 0, 0,  9,  2, 32'h0,        32'h0,    0, 0, 1, 1, 0,  2, 32'h0,        32'hA0000009);
        add(1, 0, 0, 0, 0,  9,  2, 32'h0,        32'h0,    0, 1, 1, 0, 0,  2, 32'h0,        32'h22);
        add(1, 0, 0, 0, 0,  9,  2, 32'h0,        32'h0,    0, 0, 0, 0, 0,  2, 32'h0,        32'h22);
        // req0 pulsed for the grant only; reads of address 31 then 0
        add(1, 1, 0, 0, 0, 31,  0, 32'h0,        32'h0,    0, 0, 1, 1, 0, 31, 32'h0,        32'h22);
        add(1, 0, 0, 0, 0, 31,  0, 32'h0,        32'h0,    1, 0, 1, 0, 0, 31, 32'h0,        32'hA000001F);
        add(1, 0, 1, 0, 0, 31,  0, 32'h0,        32'h0,    0, 0, 0, 0, 0, 31, 32'h0,        32'hA000001F);
        add(1, 0, 1, 0, 0, 31,  0, 32'h0,        32'h0,    0, 0, 1, 1, 0,  0, 32'h0,        32'hA000001F);
        add(1, 0, 0, 0, 0, 31,  0, 32'h0,        32'h0,    0, 1, 1, 0, 0,  0, 32'h0,        32'hA0000000);
        add(1, 0, 0, 0, 0, 31,  0, 32'h0,        32'h0,    0, 0, 0, 0, 0,  0, 32'h0,        32'hA0000000);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            reset_n = vq[i].rst;
            req0 = vq[i].r0;   req1 = vq[i].r1;
            we0 = vq[i].w0;    we1 = vq[i].w1;
            addr0 = vq[i].a0;  addr1 = vq[i].a1;
            wdata0 = vq[i].d0; wdata1 = vq[i].d1;
            @(posedge clk);
            #1;
            check("ack0",      i, 32'(ack0),      32'(vq[i].k0));
            check("ack1",      i, 32'(ack1),      32'(vq[i].k1));
            check("busy",      i, 32'(busy),      32'(vq[i].bz));
            check("mem_read",  i, 32'(mem_read),  32'(vq[i].mr));
            check("mem_write", i, 32'(mem_write), 32'(vq[i].mw));
            check("mem_addr",  i, 32'(mem_addr),  32'(vq[i].ma));
            check("mem_wdata", i, mem_wdata,      vq[i].md);
            check("rdata",     i, rdata,          vq[i].rd);
        end

        // Write latency: ack0 in the 2nd cycle after the grant edge; rdata held on a write ack.
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd4; wdata0 = 32'h1234;
        n = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) req0 = 1'b0;
            if (ack0) begin
                n = c;
                break;
            end
        end
        check("write_ack_latency", 100, 32'(n), 32'd2);
        check("rdata_hold_on_write", 100, rdata, 32'hA0000000);

        // Asynchronous reset mid-ISSUE clears the strobe without a clock edge.
        @(negedge clk);
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd6; wdata0 = 32'h77;
        @(posedge clk);
        #1;
        check("seq_issue_write", 101, 32'(mem_write), 32'd1);
        req0 = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("async_mem_write", 101, 32'(mem_write), 32'd0);
        check("async_busy",      101, 32'(busy),      32'd0);
        check("async_mem_addr",  101, 32'(mem_addr),  32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("no_ack_after_abort", 102 + c, 32'(ack0), 32'd0);
        end
        check("aborted_write_absent", 105, mem[6], 32'hA0000006);
        check("completed_write",      105, mem[4], 32'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
